// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, instruction
// field encodings, ALU function codes, mux-select encodings and the bundle of
// registered control outputs.
package cu_pkg;

    localparam int FS_W = 5;

    // FSM states. S_RESET is where the FSM sits while reset is held; the
    // first clock edge after reset releases always enters S_FETCH.
    typedef enum logic [4:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_R_ALU,
        S_WB_RD,
        S_MULDIV,
        S_WB_HI,
        S_WB_LO,
        S_JR,
        S_IMM_ALU,
        S_WB_RT,
        S_ADDR,
        S_LW_RD,
        S_WB_LW,
        S_SW_WR,
        S_BR_CMP,
        S_BR_TAKE,
        S_J,
        S_JAL_LNK,
        S_ILLEGAL,
        S_INT_SAVE,
        S_INT_VEC
    } state_t;

    // Opcodes, ir[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, ir[5:0]
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU function codes, shared with the integer ALU
    localparam logic [FS_W-1:0] FS_PASS_S = 5'h00;
    localparam logic [FS_W-1:0] FS_ADD    = 5'h02;
    localparam logic [FS_W-1:0] FS_SUB    = 5'h04;
    localparam logic [FS_W-1:0] FS_SLT    = 5'h06;
    localparam logic [FS_W-1:0] FS_AND    = 5'h08;
    localparam logic [FS_W-1:0] FS_OR     = 5'h09;
    localparam logic [FS_W-1:0] FS_MUL    = 5'h1E;
    localparam logic [FS_W-1:0] FS_DIV    = 5'h1F;

    // Y-mux sources
    localparam logic [2:0] Y_HI  = 3'd0;
    localparam logic [2:0] Y_LO  = 3'd1;
    localparam logic [2:0] Y_ALU = 3'd2;
    localparam logic [2:0] Y_DIN = 3'd3;
    localparam logic [2:0] Y_PC  = 3'd4;

    // Register-file write address
    localparam logic [1:0] D_RD = 2'd0;
    localparam logic [1:0] D_RT = 2'd1;
    localparam logic [1:0] D_RA = 2'd2;
    localparam logic [1:0] D_SP = 2'd3;

    // Next-PC source
    localparam logic [1:0] PC_BRANCH = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_RS     = 2'd2;
    localparam logic [1:0] PC_VECTOR = 2'd3;

    // All registered control outputs, so they can be decoded and registered
    // as one unit.
    typedef struct packed {
        logic            pc_ld;
        logic            pc_inc;
        logic            ir_ld;
        logic            im_cs;
        logic            im_rd;
        logic [1:0]      pc_sel;
        logic            d_en;
        logic            t_sel;
        logic            hilo_ld;
        logic [1:0]      d_sel;
        logic [2:0]      y_sel;
        logic [FS_W-1:0] fs;
        logic            dm_cs;
        logic            dm_rd;
        logic            dm_wr;
        logic            illegal;
    } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Instruction decoder: maps opcode/funct to the state entered after DECODE
// and to the ALU function used by that instruction's execute state.
module cu_decode
    import cu_pkg::*;
(
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    output state_t          dispatch,
    output logic [FS_W-1:0] alu_fs,
    output logic            is_load,
    output logic            is_bne
);

    // Opcode/funct dispatch; anything unrecognised lands in S_ILLEGAL
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        dispatch = S_ILLEGAL;
        alu_fs   = FS_PASS_S;
        is_load  = 1'b0;
        is_bne   = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin dispatch = S_R_ALU;  alu_fs = FS_ADD; end
                    FN_SUB:  begin dispatch = S_R_ALU;  alu_fs = FS_SUB; end
                    FN_AND:  begin dispatch = S_R_ALU;  alu_fs = FS_AND; end
                    FN_OR:   begin dispatch = S_R_ALU;  alu_fs = FS_OR;  end
                    FN_SLT:  begin dispatch = S_R_ALU;  alu_fs = FS_SLT; end
                    FN_MULT: begin dispatch = S_MULDIV; alu_fs = FS_MUL; end
                    FN_DIV:  begin dispatch = S_MULDIV; alu_fs = FS_DIV; end
                    FN_MFHI: dispatch = S_WB_HI;
                    FN_MFLO: dispatch = S_WB_LO;
                    FN_JR:   dispatch = S_JR;
                    default: dispatch = S_ILLEGAL;
                endcase
            end
            OP_ADDI: begin dispatch = S_IMM_ALU; alu_fs = FS_ADD; end
            OP_ORI:  begin dispatch = S_IMM_ALU; alu_fs = FS_OR;  end
            OP_LW:   begin dispatch = S_ADDR; alu_fs = FS_ADD; is_load = 1'b1; end
            OP_SW:   begin dispatch = S_ADDR; alu_fs = FS_ADD; end
            OP_BEQ:  begin dispatch = S_BR_CMP; alu_fs = FS_SUB; end
            OP_BNE:  begin dispatch = S_BR_CMP; alu_fs = FS_SUB; is_bne = 1'b1; end
            OP_J:    dispatch = S_J;
            OP_JAL:  dispatch = S_JAL_LNK;
            default: dispatch = S_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control unit. Moore FSM whose outputs are registered decodes of
// the state being entered, so every strobe is valid from the edge that enters
// its state. Optional interrupt support is enabled by defining CU_INTR_EN.
module control_unit
    import cu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     ir,
    input  logic            n,
    input  logic            z,
    input  logic            c,
    input  logic            v,
`ifdef CU_INTR_EN
    input  logic            intr,
    output logic            int_ack,
`endif
    output logic            pc_ld,
    output logic            pc_inc,
    output logic            ir_ld,
    output logic            im_cs,
    output logic            im_rd,
    output logic [1:0]      pc_sel,
    output logic            d_en,
    output logic            t_sel,
    output logic            hilo_ld,
    output logic [1:0]      d_sel,
    output logic [2:0]      y_sel,
    output logic [FS_W-1:0] fs,
    output logic            dm_cs,
    output logic            dm_rd,
    output logic            dm_wr,
    output logic            illegal
);

    state_t          state, state_next, done_next, dispatch;
    ctrl_t           ctrl, ctrl_next;
    logic [FS_W-1:0] alu_fs;
    logic            is_load, is_bne;

    // Only z steers sequencing; the remaining flags and ir fields belong to
    // the datapath.
    logic unused_inputs;
    assign unused_inputs = ^{n, c, v, ir[25:6]};

    cu_decode u_decode (
        .op       (ir[31:26]),
        .funct    (ir[5:0]),
        .dispatch (dispatch),
        .alu_fs   (alu_fs),
        .is_load  (is_load),
        .is_bne   (is_bne)
    );

    // State that follows the last cycle of an instruction
`ifdef CU_INTR_EN
    assign done_next = intr ? S_INT_SAVE : S_FETCH;
`else
    assign done_next = S_FETCH;
`endif

    // Next-state sequencing
    always_comb begin
        state_next = state;
        case (state)
            S_RESET:    state_next = S_FETCH;
            S_FETCH:    state_next = S_DECODE;
            S_DECODE:   state_next = dispatch;
            S_R_ALU:    state_next = S_WB_RD;
            S_IMM_ALU:  state_next = S_WB_RT;
            S_ADDR:     state_next = is_load ? S_LW_RD : S_SW_WR;
            S_LW_RD:    state_next = S_WB_LW;
            S_BR_CMP:   state_next = (z ^ is_bne) ? S_BR_TAKE : done_next;
            S_JAL_LNK:  state_next = S_J;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            S_INT_SAVE: state_next = S_INT_VEC;
            S_INT_VEC:  state_next = S_FETCH;
            S_WB_RD, S_MULDIV, S_WB_HI, S_WB_LO, S_JR, S_WB_RT,
            S_WB_LW, S_SW_WR, S_BR_TAKE, S_J:
                        state_next = done_next;
            default:    state_next = S_FETCH;
        endcase
    end

    // Control outputs for the state about to be entered
    always_comb begin
        ctrl_next = '0;
        case (state_next)
            S_FETCH: begin
                ctrl_next.im_cs  = 1'b1;
                ctrl_next.im_rd  = 1'b1;
                ctrl_next.ir_ld  = 1'b1;
                ctrl_next.pc_inc = 1'b1;
            end
            S_R_ALU:   ctrl_next.fs = alu_fs;
            S_WB_RD: begin
                ctrl_next.d_en  = 1'b1;
                ctrl_next.d_sel = D_RD;
                ctrl_next.y_sel = Y_ALU;
            end
            S_MULDIV: begin
                ctrl_next.fs      = alu_fs;
                ctrl_next.hilo_ld = 1'b1;
            end
            S_WB_HI, S_WB_LO: begin
                ctrl_next.d_en  = 1'b1;
                ctrl_next.d_sel = D_RD;
                ctrl_next.y_sel = (state_next == S_WB_HI) ? Y_HI : Y_LO;
            end
            S_JR: begin
                ctrl_next.pc_sel = PC_RS;
                ctrl_next.pc_ld  = 1'b1;
            end
            S_IMM_ALU: begin
                ctrl_next.t_sel = 1'b1;
                ctrl_next.fs    = alu_fs;
            end
            S_WB_RT: begin
                ctrl_next.d_en  = 1'b1;
                ctrl_next.d_sel = D_RT;
                ctrl_next.y_sel = Y_ALU;
            end
            S_ADDR: begin
                ctrl_next.t_sel = 1'b1;
                ctrl_next.fs    = FS_ADD;
            end
            S_LW_RD: begin
                ctrl_next.dm_cs = 1'b1;
                ctrl_next.dm_rd = 1'b1;
            end
            S_WB_LW: begin
                ctrl_next.d_en  = 1'b1;
                ctrl_next.d_sel = D_RT;
                ctrl_next.y_sel = Y_DIN;
            end
            S_SW_WR: begin
                ctrl_next.dm_cs = 1'b1;
                ctrl_next.dm_wr = 1'b1;
            end
            S_BR_CMP:  ctrl_next.fs = FS_SUB;
            S_BR_TAKE: begin
                ctrl_next.pc_sel = PC_BRANCH;
                ctrl_next.pc_ld  = 1'b1;
            end
            S_J: begin
                ctrl_next.pc_sel = PC_JUMP;
                ctrl_next.pc_ld  = 1'b1;
            end
            S_JAL_LNK, S_INT_SAVE: begin
                ctrl_next.d_en  = 1'b1;
                ctrl_next.d_sel = D_RA;
                ctrl_next.y_sel = Y_PC;
            end
            S_INT_VEC: begin
                ctrl_next.pc_sel = PC_VECTOR;
                ctrl_next.pc_ld  = 1'b1;
            end
            S_ILLEGAL: ctrl_next.illegal = 1'b1;
            default:   ctrl_next = '0;
        endcase
    end

    // State and output registers; reset drops every strobe at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
            ctrl  <= '0;
        end else begin
            // NOTE: non-blocking so state and outputs update together from
            // pre-edge values.
            state <= state_next;
            ctrl  <= ctrl_next;
        end
    end

`ifdef CU_INTR_EN
    // Interrupt acknowledge, high for the single INT_VEC cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) int_ack <= 1'b0;
        else       int_ack <= (state_next == S_INT_VEC);
    end
`endif

    assign pc_ld   = ctrl.pc_ld;
    assign pc_inc  = ctrl.pc_inc;
    assign ir_ld   = ctrl.ir_ld;
    assign im_cs   = ctrl.im_cs;
    assign im_rd   = ctrl.im_rd;
    assign pc_sel  = ctrl.pc_sel;
    assign d_en    = ctrl.d_en;
    assign t_sel   = ctrl.t_sel;
    assign hilo_ld = ctrl.hilo_ld;
    assign d_sel   = ctrl.d_sel;
    assign y_sel   = ctrl.y_sel;
    assign fs      = ctrl.fs;
    assign dm_cs   = ctrl.dm_cs;
    assign dm_rd   = ctrl.dm_rd;
    assign dm_wr   = ctrl.dm_wr;
    assign illegal = ctrl.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: steps each instruction class through
// its states and compares the registered controls against hand-derived values.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        n = 1'b0, z = 1'b0, c = 1'b0, v = 1'b0;
    logic        pc_ld, pc_inc, ir_ld, im_cs, im_rd;
    logic [1:0]  pc_sel, d_sel;
    logic        d_en, t_sel, hilo_ld;
    logic [2:0]  y_sel;
    logic [4:0]  fs;
    logic        dm_cs, dm_rd, dm_wr, illegal;
`ifdef CU_INTR_EN
    logic        intr = 1'b0;
    logic        int_ack;
`endif

    int total = 0;
    int bad = 0;
    int multi_strobe = 0;

    control_unit dut (
        .clk     (clk),
        .reset   (reset),
        .ir      (ir),
        .n       (n),
        .z       (z),
        .c       (c),
        .v       (v),
`ifdef CU_INTR_EN
        .intr    (intr),
        .int_ack (int_ack),
`endif
        .pc_ld   (pc_ld),
        .pc_inc  (pc_inc),
        .ir_ld   (ir_ld),
        .im_cs   (im_cs),
        .im_rd   (im_rd),
        .pc_sel  (pc_sel),
        .d_en    (d_en),
        .t_sel   (t_sel),
        .hilo_ld (hilo_ld),
        .d_sel   (d_sel),
        .y_sel   (y_sel),
        .fs      (fs),
        .dm_cs   (dm_cs),
        .dm_rd   (dm_rd),
        .dm_wr   (dm_wr),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // At most one of the write strobes may be high in any cycle
    always @(negedge clk) begin
        if (!reset && (int'(d_en) + int'(dm_wr) + int'(pc_ld) + int'(hilo_ld)) > 1)
            multi_strobe++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {8'h0, pc_ld, pc_inc, ir_ld, im_cs, im_rd, pc_sel, d_en, t_sel, hilo_ld,
                d_sel, y_sel, fs, dm_cs, dm_rd, dm_wr, illegal};
    endfunction

    // {im_cs, im_rd, ir_ld, pc_inc, pc_ld, d_en}
    task automatic check_fetch(input string tag);
        check(tag, {26'h0, im_cs, im_rd, ir_ld, pc_inc, pc_ld, d_en}, 32'h3C);
    endtask

    // {d_en, d_sel, y_sel}
    task automatic check_wb(input string tag, input logic [1:0] ds, input logic [2:0] ys);
        check(tag, {26'h0, d_en, d_sel, y_sel}, {26'h0, 1'b1, ds, ys});
    endtask

    // {pc_ld, pc_sel, d_en}
    task automatic check_pc(input string tag, input logic [1:0] ps);
        check(tag, {28'h0, pc_ld, pc_sel, d_en}, {28'h0, 1'b1, ps, 1'b0});
    endtask

    int pc_ld_seen;
    int illegal_bad;

    initial begin
        // Reset state
        ir = 32'h00221820;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // ADD $3,$1,$2
        step(); check_fetch("add_fetch");
        step(); check("add_decode", all_outs(), 32'h0);
        step(); check("add_r_alu", {24'h0, fs, t_sel, d_en, 1'b0}, {24'h0, 5'h02, 3'b000});
        step(); check_wb("add_wb_rd", 2'd0, 3'd2);
        step(); check_fetch("add_next_fetch");

        // Reset asserted in R_ALU: outputs drop without waiting for an edge
        step(); step();
        check("r_alu_before_reset", {27'h0, fs}, 32'h02);
        #2 reset = 1'b1;
        #1 check("reset_mid_outputs", all_outs(), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(); check_fetch("post_reset_fetch");

        // LW $5,8($4)
        ir = 32'h8C850008;
        step();
        step(); check("lw_addr", {26'h0, t_sel, fs}, {26'h0, 1'b1, 5'h02});
        step(); check("lw_rd", {29'h0, dm_cs, dm_rd, d_en}, 32'h6);
        step(); check("lw_dm_rd_drop", {31'h0, dm_rd}, 32'h0);
        check_wb("lw_wb", 2'd1, 3'd3);
        step(); check_fetch("lw_fetch_after_5");

        // BEQ taken (z=1)
        ir = 32'h10220003; z = 1'b1;
        step();
        step(); check("beq_cmp_fs", {27'h0, fs}, 32'h04);
        step(); check_pc("beq_taken", 2'd0);
        step(); check_fetch("beq_taken_fetch");

        // BEQ not taken (z=0): back to FETCH after 3 cycles, pc_ld never high
        z = 1'b0; pc_ld_seen = 0;
        step(); pc_ld_seen += int'(pc_ld);
        step(); pc_ld_seen += int'(pc_ld);
        step(); pc_ld_seen += int'(pc_ld);
        check_fetch("beq_not_taken_fetch");
        check("beq_not_taken_pc_ld", pc_ld_seen, 0);

        // BNE taken (z=0)
        ir = 32'h14220003;
        step(); step();
        step(); check_pc("bne_taken", 2'd0);
        step(); check_fetch("bne_fetch");

        // JAL
        ir = 32'h0C000010;
        step();
        step(); check_wb("jal_link", 2'd2, 3'd4);
        step(); check_pc("jal_jump", 2'd1);
        step(); check_fetch("jal_fetch");

        // MULT $1,$2
        ir = 32'h00220018;
        step();
        step(); check("mult", {26'h0, hilo_ld, fs}, {26'h0, 1'b1, 5'h1E});
        step(); check_fetch("mult_fetch");

        // MFLO $3
        ir = 32'h00001812;
        step();
        step(); check_wb("mflo_wb", 2'd0, 3'd1);
        step(); check_fetch("mflo_fetch");

        // JR $31
        ir = 32'h03E00008;
        step();
        step(); check_pc("jr", 2'd2);
        step(); check_fetch("jr_fetch");

        // SW $5,8($4)
        ir = 32'hAC850008;
        step();
        step(); check("sw_addr", {26'h0, t_sel, fs}, {26'h0, 1'b1, 5'h02});
        step(); check("sw_wr", {29'h0, dm_cs, dm_wr, d_en}, 32'h6);
        step(); check_fetch("sw_fetch");

        // ORI $5,$4,0xF
        ir = 32'h3485000F;
        step();
        step(); check("ori_alu", {26'h0, t_sel, fs}, {26'h0, 1'b1, 5'h09});
        step(); check_wb("ori_wb_rt", 2'd1, 3'd2);
        step(); check_fetch("ori_fetch");

        // Illegal opcode: sticky, no writes for 100 cycles
        ir = 32'hFC000000;
        step();
        step(); check("illegal_set", {31'h0, illegal}, 32'h1);
        illegal_bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (illegal !== 1'b1 || d_en !== 1'b0 || dm_wr !== 1'b0 || pc_ld !== 1'b0
                || im_rd !== 1'b0)
                illegal_bad++;
        end
        check("illegal_held_100", illegal_bad, 0);
        reset = 1'b1;
        #1 check("illegal_cleared", {31'h0, illegal}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ir = 32'h00221820;
        step(); check_fetch("illegal_reset_fetch");

        check("one_write_strobe", multi_strobe, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
